hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/hazard_scoreboard_if.sv | 37 +++
 rtl/hazard_src_resolve.sv | 48 ++++
 rtl/hazard_scoreboard.sv | 95 +++++++++
 tb/tb_hazard_scoreboard.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the issue-stage hazard logic.
// Scoreboard entries store a zero-extended register index so one struct serves any REG_BITS up to REG_BITS_MAX.
package cpu_pkg;
   localparam int REG_BITS_DEF = 5;
   localparam int DATA_W_DEF   = 32;
   localparam int REG_BITS_MAX = 8;

   localparam logic [3:0] SEL_RF = 4'd0;

   typedef logic [REG_BITS_MAX-1:0] reg_idx_t;

   typedef struct packed {
      logic     valid;
      logic     wr_en;
      reg_idx_t rd;
   } sb_entry_t;

   // Entry k forwards with select code k+1.
   function automatic logic [3:0] sel_from_entry(input int k);
      return 4'(k + 1);
   endfunction
endpackage

// File: rtl/hazard_scoreboard_if.sv
// Issue-slot, pipeline-result and hazard-response signals between the ID stage and the scoreboard.
// The master modport is the ID stage side; the slave modport is the scoreboard side.
interface hazard_scoreboard_if #(
   parameter int REG_BITS = cpu_pkg::REG_BITS_DEF,
   parameter int DATA_W   = cpu_pkg::DATA_W_DEF,
   parameter int DEPTH    = 3,
   parameter int CNT_W    = 16
);
   logic                    id_valid;
   logic [REG_BITS-1:0]     id_rs;
   logic [REG_BITS-1:0]     id_rt;
   logic                    id_rs_used;
   logic                    id_rt_used;
   logic                    id_wr_en;
   logic [REG_BITS-1:0]     id_wr_reg;
   logic                    flush;
   logic [DEPTH*DATA_W-1:0] stage_data;
   logic [DEPTH-1:0]        stage_data_ok;
   logic                    stall;
   logic [3:0]              fwd_sel_rs;
   logic [3:0]              fwd_sel_rt;
   logic [DATA_W-1:0]       fwd_rs_data;
   logic [DATA_W-1:0]       fwd_rt_data;
   logic [CNT_W-1:0]        stall_count;

   modport master (
      output id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_wr_en, id_wr_reg,
      output flush, stage_data, stage_data_ok,
      input  stall, fwd_sel_rs, fwd_sel_rt, fwd_rs_data, fwd_rt_data, stall_count
   );

   modport slave (
      input  id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_wr_en, id_wr_reg,
      input  flush, stage_data, stage_data_ok,
      output stall, fwd_sel_rs, fwd_sel_rt, fwd_rs_data, fwd_rt_data, stall_count
   );
endinterface

// File: rtl/hazard_src_resolve.sv
// Resolves one source operand against the in-flight scoreboard: youngest matching producer wins,
// then either forwards its final result or requests a stall.
module hazard_src_resolve import cpu_pkg::*; #(
   parameter int REG_BITS = REG_BITS_DEF,
   parameter int DATA_W   = DATA_W_DEF,
   parameter int DEPTH    = 3,
   parameter int FWD_EN   = 1
) (
   input  logic                    src_used_i,
   input  logic [REG_BITS-1:0]     src_idx_i,
   input  sb_entry_t [DEPTH-1:0]   entries_i,
   input  logic [DEPTH*DATA_W-1:0] stage_data_i,
   input  logic [DEPTH-1:0]        stage_data_ok_i,
   output logic                    need_stall_o,
   output logic [3:0]              fwd_sel_o,
   output logic [DATA_W-1:0]       fwd_data_o
);
   logic [DEPTH-1:0] match;

   // r0 is hardwired, so it never creates a dependency.
   always_comb begin
      match = '0;
      for (int k = 0; k < DEPTH; k++) begin
         match[k] = src_used_i && (src_idx_i != '0) && entries_i[k].valid &&
                    entries_i[k].wr_en && (entries_i[k].rd == reg_idx_t'(src_idx_i));
      end
   end

   // Walk oldest to youngest so the lowest matching k has the last word.
   always_comb begin
      need_stall_o = 1'b0;
      fwd_sel_o    = SEL_RF;
      fwd_data_o   = '0;
      for (int k = DEPTH-1; k >= 0; k--) begin
         if (match[k]) begin
            if (FWD_EN != 0 && stage_data_ok_i[k]) begin
               need_stall_o = 1'b0;
               fwd_sel_o    = sel_from_entry(k);
               fwd_data_o   = stage_data_i[k*DATA_W +: DATA_W];
            end else begin
               need_stall_o = 1'b1;
               fwd_sel_o    = SEL_RF;
               fwd_data_o   = '0;
            end
         end
      end
   end
endmodule

// File: rtl/hazard_scoreboard.sv
// In-order pipeline hazard scoreboard: tracks DEPTH in-flight writers after issue, resolves rs/rt
// dependencies combinationally and counts stall cycles with saturation.
module hazard_scoreboard import cpu_pkg::*; #(
   parameter int REG_BITS = REG_BITS_DEF,
   parameter int DATA_W   = DATA_W_DEF,
   parameter int DEPTH    = 3,
   parameter int FWD_EN   = 1,
   parameter int CNT_W    = 16
) (
   input  logic               clka,
   input  logic               rst_n,
   hazard_scoreboard_if.slave bus
);
   sb_entry_t [DEPTH-1:0] entries_q;
   sb_entry_t [DEPTH-1:0] entries_d;
   logic [CNT_W-1:0]      stall_count_q;
   logic [CNT_W-1:0]      stall_count_d;

   logic       stall_rs;
   logic       stall_rt;
   logic       stall;
   logic       issue;
   logic [3:0] sel_rs;
   logic [3:0] sel_rt;
   logic [DATA_W-1:0] data_rs;
   logic [DATA_W-1:0] data_rt;

   hazard_src_resolve #(
      .REG_BITS(REG_BITS), .DATA_W(DATA_W), .DEPTH(DEPTH), .FWD_EN(FWD_EN)
   ) u_rs (
      .src_used_i      (bus.id_rs_used),
      .src_idx_i       (bus.id_rs),
      .entries_i       (entries_q),
      .stage_data_i    (bus.stage_data),
      .stage_data_ok_i (bus.stage_data_ok),
      .need_stall_o    (stall_rs),
      .fwd_sel_o       (sel_rs),
      .fwd_data_o      (data_rs)
   );

   hazard_src_resolve #(
      .REG_BITS(REG_BITS), .DATA_W(DATA_W), .DEPTH(DEPTH), .FWD_EN(FWD_EN)
   ) u_rt (
      .src_used_i      (bus.id_rt_used),
      .src_idx_i       (bus.id_rt),
      .entries_i       (entries_q),
      .stage_data_i    (bus.stage_data),
      .stage_data_ok_i (bus.stage_data_ok),
      .need_stall_o    (stall_rt),
      .fwd_sel_o       (sel_rt),
      .fwd_data_o      (data_rt)
   );

   assign stall = bus.id_valid && !bus.flush && (stall_rs || stall_rt);
   assign issue = bus.id_valid && !stall && !bus.flush;

   // Flush kills everything in flight as well as the instruction trying to issue.
   always_comb begin
      entries_d = '0;
      if (!bus.flush) begin
         if (issue) begin
            entries_d[0].valid = 1'b1;
            entries_d[0].wr_en = bus.id_wr_en;
            entries_d[0].rd    = reg_idx_t'(bus.id_wr_reg);
         end
         for (int k = 1; k < DEPTH; k++) begin
            entries_d[k] = entries_q[k-1];
         end
      end
   end

   always_comb begin
      stall_count_d = stall_count_q;
      if (stall && (stall_count_q != '1)) begin
         stall_count_d = stall_count_q + 1'b1;
      end
   end

   always_ff @(posedge clka or negedge rst_n) begin
      if (!rst_n) begin
         entries_q     <= '0;
         stall_count_q <= '0;
      end else begin
         entries_q     <= entries_d;
         stall_count_q <= stall_count_d;
      end
   end

   assign bus.stall       = stall;
   assign bus.fwd_sel_rs  = sel_rs;
   assign bus.fwd_sel_rt  = sel_rt;
   assign bus.fwd_rs_data = data_rs;
   assign bus.fwd_rt_data = data_rt;
   assign bus.stall_count = stall_count_q;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: three instances (forwarding, stall-only, 4-bit counter) share one
// stimulus stream and are compared against an issue-history model plus directed expectations.
module tb_hazard_scoreboard;
   localparam int DEPTH = 3;

   logic        clka;
   logic        rst_n;
   logic        id_valid;
   logic [4:0]  id_rs, id_rt, id_wr_reg;
   logic        id_rs_used, id_rt_used, id_wr_en, flush;
   logic [95:0] stage_data;
   logic [2:0]  stage_data_ok;

   int checks = 0;
   int errors = 0;

   hazard_scoreboard_if #(.DEPTH(DEPTH), .CNT_W(16)) if0 ();
   hazard_scoreboard_if #(.DEPTH(DEPTH), .CNT_W(16)) if1 ();
   hazard_scoreboard_if #(.DEPTH(DEPTH), .CNT_W(4))  if2 ();

   hazard_scoreboard #(.DEPTH(DEPTH), .FWD_EN(1), .CNT_W(16)) u_fwd   (.clka(clka), .rst_n(rst_n), .bus(if0.slave));
   hazard_scoreboard #(.DEPTH(DEPTH), .FWD_EN(0), .CNT_W(16)) u_nofwd (.clka(clka), .rst_n(rst_n), .bus(if1.slave));
   hazard_scoreboard #(.DEPTH(DEPTH), .FWD_EN(1), .CNT_W(4))  u_cnt4  (.clka(clka), .rst_n(rst_n), .bus(if2.slave));

   assign if0.id_valid = id_valid;   assign if1.id_valid = id_valid;   assign if2.id_valid = id_valid;
   assign if0.id_rs = id_rs;         assign if1.id_rs = id_rs;         assign if2.id_rs = id_rs;
   assign if0.id_rt = id_rt;         assign if1.id_rt = id_rt;         assign if2.id_rt = id_rt;
   assign if0.id_rs_used = id_rs_used; assign if1.id_rs_used = id_rs_used; assign if2.id_rs_used = id_rs_used;
   assign if0.id_rt_used = id_rt_used; assign if1.id_rt_used = id_rt_used; assign if2.id_rt_used = id_rt_used;
   assign if0.id_wr_en = id_wr_en;   assign if1.id_wr_en = id_wr_en;   assign if2.id_wr_en = id_wr_en;
   assign if0.id_wr_reg = id_wr_reg; assign if1.id_wr_reg = id_wr_reg; assign if2.id_wr_reg = id_wr_reg;
   assign if0.flush = flush;         assign if1.flush = flush;         assign if2.flush = flush;
   assign if0.stage_data = stage_data; assign if1.stage_data = stage_data; assign if2.stage_data = stage_data;
   assign if0.stage_data_ok = stage_data_ok; assign if1.stage_data_ok = stage_data_ok; assign if2.stage_data_ok = stage_data_ok;

   logic        o_stall [3];
   logic [3:0]  o_srs [3];
   logic [3:0]  o_srt [3];
   logic [31:0] o_drs [3];
   logic [31:0] o_drt [3];
   logic [15:0] o_cnt [3];

   assign o_stall[0] = if0.stall;  assign o_stall[1] = if1.stall;  assign o_stall[2] = if2.stall;
   assign o_srs[0] = if0.fwd_sel_rs; assign o_srs[1] = if1.fwd_sel_rs; assign o_srs[2] = if2.fwd_sel_rs;
   assign o_srt[0] = if0.fwd_sel_rt; assign o_srt[1] = if1.fwd_sel_rt; assign o_srt[2] = if2.fwd_sel_rt;
   assign o_drs[0] = if0.fwd_rs_data; assign o_drs[1] = if1.fwd_rs_data; assign o_drs[2] = if2.fwd_rs_data;
   assign o_drt[0] = if0.fwd_rt_data; assign o_drt[1] = if1.fwd_rt_data; assign o_drt[2] = if2.fwd_rt_data;
   assign o_cnt[0] = if0.stall_count; assign o_cnt[1] = if1.stall_count; assign o_cnt[2] = {12'd0, if2.stall_count};

   initial clka = 1'b0;
   always #5 clka = ~clka;

   // Reference model: a list of issued instructions stamped with their issue cycle.
   typedef struct { int cyc; bit wr; int rd; } rec_t;
   rec_t hist [3][$];
   int   scnt [3];
   int   now = 0;
   bit   fwd_mode [3] = '{1'b1, 1'b0, 1'b1};
   int   cnt_max  [3] = '{65535, 65535, 15};

   function automatic void resolve(input int d, input bit used, input int idx,
                                   output bit st, output int sel, output logic [31:0] data);
      int best = -1;
      for (int i = 0; i < hist[d].size(); i++) begin
         int age = now - hist[d][i].cyc - 1;
         if (used && idx != 0 && hist[d][i].wr && hist[d][i].rd == idx &&
             age >= 0 && age < DEPTH && (best < 0 || age < best))
            best = age;
      end
      st = 0; sel = 0; data = '0;
      if (best >= 0) begin
         if (fwd_mode[d] && stage_data_ok[best]) begin
            sel  = best + 1;
            data = stage_data[best*32 +: 32];
         end else begin
            st = 1;
         end
      end
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      id_valid = 0; id_rs = 0; id_rt = 0; id_rs_used = 0; id_rt_used = 0;
      id_wr_en = 0; id_wr_reg = 0; flush = 0; stage_data = '0; stage_data_ok = '0;
   endtask

   task automatic issue(input int rs, input bit rs_u, input int rt, input bit rt_u, input bit wr, input int rd);
      id_valid = 1; id_rs = 5'(rs); id_rs_used = rs_u; id_rt = 5'(rt); id_rt_used = rt_u;
      id_wr_en = wr; id_wr_reg = 5'(rd);
   endtask

   // Compare every instance with the model mid-cycle, then advance the model across the edge.
   task automatic step();
      @(negedge clka);
      for (int d = 0; d < 3; d++) begin
         bit sa, sb, es;
         int sela, selb;
         logic [31:0] da, db;
         resolve(d, id_rs_used, int'(id_rs), sa, sela, da);
         resolve(d, id_rt_used, int'(id_rt), sb, selb, db);
         es = id_valid && !flush && (sa || sb);
         chk($sformatf("m%0d_stall@%0d", d, now), 64'(o_stall[d]), 64'(es));
         chk($sformatf("m%0d_sel_rs@%0d", d, now), 64'(o_srs[d]), 64'(sela));
         chk($sformatf("m%0d_sel_rt@%0d", d, now), 64'(o_srt[d]), 64'(selb));
         chk($sformatf("m%0d_data_rs@%0d", d, now), 64'(o_drs[d]), 64'(da));
         chk($sformatf("m%0d_data_rt@%0d", d, now), 64'(o_drt[d]), 64'(db));
         chk($sformatf("m%0d_count@%0d", d, now), 64'(o_cnt[d]), 64'(scnt[d]));
         if (es && scnt[d] < cnt_max[d]) scnt[d]++;
         if (flush) hist[d].delete();
         else if (id_valid && !es) hist[d].push_back('{now, id_wr_en, int'(id_wr_reg)});
         while (hist[d].size() > 0 && now - hist[d][0].cyc >= DEPTH) void'(hist[d].pop_front());
      end
      now++;
      @(posedge clka); #1;
   endtask

   task automatic do_reset();
      rst_n = 0;
      #2;
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("rst%0d_stall", d), 64'(o_stall[d]), 64'd0);
         chk($sformatf("rst%0d_sel_rs", d), 64'(o_srs[d]), 64'd0);
         chk($sformatf("rst%0d_sel_rt", d), 64'(o_srt[d]), 64'd0);
         chk($sformatf("rst%0d_data_rs", d), 64'(o_drs[d]), 64'd0);
         chk($sformatf("rst%0d_count", d), 64'(o_cnt[d]), 64'd0);
         hist[d].delete();
         scnt[d] = 0;
      end
      @(posedge clka); #1;
      rst_n = 1;
   endtask

   initial begin
      bit exp40 [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
      rst_n = 1;
      idle();
      #1;
      do_reset();

      // Forward a fresh ALU result from entry 0.
      issue(0, 0, 0, 0, 1, 3); step();
      issue(3, 1, 0, 0, 0, 0); stage_data_ok = 3'b001; stage_data[31:0] = 32'h1234; #1;
      chk("alu_fwd_stall", 64'(o_stall[0]), 64'd0);
      chk("alu_fwd_sel", 64'(o_srs[0]), 64'd1);
      chk("alu_fwd_data", 64'(o_drs[0]), 64'h1234);
      chk("alu_nofwd_stall", 64'(o_stall[1]), 64'd1);
      step(); idle(); step();

      // Load-use: one stall, then forward from entry 1.
      do_reset();
      issue(0, 0, 0, 0, 1, 5); step();
      issue(0, 0, 5, 1, 0, 0); stage_data_ok = 3'b000; #1;
      chk("load_use_stall", 64'(o_stall[0]), 64'd1);
      step();
      stage_data_ok = 3'b010; stage_data[63:32] = 32'h55; #1;
      chk("load_use_stall2", 64'(o_stall[0]), 64'd0);
      chk("load_use_sel", 64'(o_srt[0]), 64'd2);
      chk("load_use_data", 64'(o_drt[0]), 64'h55);
      chk("load_use_count", 64'(o_cnt[0]), 64'd1);
      step(); idle(); step();

      // Stall-only mode waits for the producer to retire.
      do_reset();
      issue(0, 0, 0, 0, 1, 7); step();
      issue(7, 1, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         #1;
         chk($sformatf("nofwd_stall_c%0d", i), 64'(o_stall[1]), 64'(exp40[i]));
         chk($sformatf("nofwd_sel_c%0d", i), 64'(o_srs[1]), 64'd0);
         if (i == 3) chk("nofwd_count", 64'(o_cnt[1]), 64'd3);
         step();
      end
      idle(); step();

      // Two writers of r4: the youngest wins.
      do_reset();
      issue(0, 0, 0, 0, 1, 4); step();
      issue(0, 0, 0, 0, 1, 4); step();
      issue(4, 1, 0, 0, 0, 0); stage_data_ok = 3'b011;
      stage_data[31:0] = 32'hA; stage_data[63:32] = 32'hB; #1;
      chk("youngest_sel", 64'(o_srs[0]), 64'd1);
      chk("youngest_data", 64'(o_drs[0]), 64'hA);
      step(); idle(); step();

      // r0 never matches; flush empties the scoreboard.
      do_reset();
      issue(0, 0, 0, 0, 1, 0); step();
      issue(0, 1, 0, 1, 0, 0); #1;
      chk("r0_stall", 64'(o_stall[1]), 64'd0);
      chk("r0_sel", 64'(o_srs[0]), 64'd0);
      step();
      issue(0, 0, 0, 0, 1, 9);  step();
      issue(0, 0, 0, 0, 1, 10); step();
      issue(0, 0, 0, 0, 1, 11); step();
      issue(11, 1, 0, 0, 0, 0); flush = 1; #1;
      chk("flush_no_stall", 64'(o_stall[1]), 64'd0);
      step();
      flush = 0; issue(11, 1, 10, 1, 0, 0); #1;
      chk("post_flush_stall", 64'(o_stall[1]), 64'd0);
      chk("post_flush_sel_rs", 64'(o_srs[1]), 64'd0);
      step(); idle(); step();

      // Self-dependent chain keeps stalling; 4-bit counter saturates; reset mid-stall.
      do_reset();
      issue(6, 1, 0, 0, 1, 6);
      for (int i = 0; i < 42; i++) step();
      #1;
      chk("sat_count", 64'(o_cnt[2]), 64'd15);
      chk("chain_mid_stall", 64'(o_stall[2]), 64'd1);
      do_reset();
      #1;
      chk("post_reset_stall", 64'(o_stall[0]), 64'd0);
      chk("post_reset_stall_nofwd", 64'(o_stall[1]), 64'd0);
      step(); idle(); step();

      // Randomized traffic with a reset in the middle.
      do_reset();
      for (int i = 0; i < 400; i++) begin
         id_valid      = ($urandom_range(0, 3) != 0);
         id_rs         = 5'($urandom_range(0, 5));
         id_rt         = 5'($urandom_range(0, 5));
         id_rs_used    = 1'($urandom_range(0, 1));
         id_rt_used    = 1'($urandom_range(0, 1));
         id_wr_en      = ($urandom_range(0, 4) != 0);
         id_wr_reg     = 5'($urandom_range(0, 5));
         flush         = ($urandom_range(0, 15) == 0);
         stage_data    = {$urandom, $urandom, $urandom};
         stage_data_ok = 3'($urandom_range(0, 7));
         if (i == 200) do_reset();
         step();
      end

      idle();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish, observed running expected finished");
      $fatal(1, "timeout");
   end
endmodule
